// File: rtl/lsu_byte_initiator_if.sv
// CPU request/response and byte-wide memory handshake bundle for the LSU byte initiator.
// The initiator itself uses the master view; the CPU/memory environment uses the slave view.
interface lsu_byte_initiator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  mem_ack;
    logic [7:0]            mem_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_byte_initiator.sv
// Splits one word/half/byte load or store into little-endian single-byte memory beats,
// reassembles load data with sign/zero extension and returns one response per request.
module lsu_byte_initiator #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    lsu_byte_initiator_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic                  accept;
    logic                  we_q, uns_q, err_q;
    logic [1:0]            size_q;
    logic [1:0]            idx_q;
    logic [1:0]            last_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] asm_q;

    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] raw,
                                                          input logic [1:0] size,
                                                          input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = raw[7:0];
        h = raw[15:0];
        extend_load = raw;
        if (size == 2'b00) begin
            if (uns) extend_load = {24'b0, raw[7:0]};
            else     extend_load = DATA_WIDTH'(b);
        end else if (size == 2'b01) begin
            if (uns) extend_load = {16'b0, raw[15:0]};
            else     extend_load = DATA_WIDTH'(h);
        end
    endfunction

    // req_ready is gated by rst_n so it reads 0 while reset is held
    assign accept = (state_q == IDLE) && rst_n && bus.req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = rst_n;
                if (accept) state_d = (bus.req_size == 2'b11) ? RESP : ACCESS;
            end
            ACCESS: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = addr_q + ADDR_WIDTH'(idx_q);
                bus.mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
                if (bus.mem_ack && (idx_q == last_q)) state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                if (!err_q && !we_q) bus.resp_rdata = extend_load(asm_q, size_q, uns_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            idx_q   <= 2'b00;
            last_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            err_q   <= (bus.req_size == 2'b11);
            size_q  <= bus.req_size;
            idx_q   <= 2'b00;
            // last beat index: 0, 1 or 3 for byte, half, word
            last_q  <= (bus.req_size == 2'b00) ? 2'd0 : (bus.req_size == 2'b01) ? 2'd1 : 2'd3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            asm_q   <= '0;
        end else if ((state_q == ACCESS) && bus.mem_ack) begin
            if (!we_q) asm_q[{idx_q, 3'b000} +: 8] <= bus.mem_rdata;
            idx_q <= idx_q + 2'd1;
        end
    end
endmodule

// File: tb/tb_lsu_byte_initiator.sv
// Bench for lsu_byte_initiator: directed vector table, reset-abort sequence and
// randomized requests against a byte-array reference model.
module tb_lsu_byte_initiator;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   wait_cycles = 0;

    bit [7:0]    dut_mem[bit [31:0]];
    bit [7:0]    ref_mem[bit [31:0]];
    logic [31:0] beat_addr_q[$];
    logic        beat_we_q[$];
    logic [7:0]  beat_wd_q[$];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;
    vec_t vecs[$];

    lsu_byte_initiator_if bus();

    lsu_byte_initiator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        dut_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Reference: the request as a whole, on a plain byte array, with arithmetic extension
    task automatic ref_exec(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        longint val;
        int     n;
        rdata = '0;
        err   = 1'b0;
        if (size == 2'b11) begin
            err = 1'b1;
            return;
        end
        n = 1 << size;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = 8'(wdata >> (8 * i));
        end else begin
            val = 0;
            for (int i = n - 1; i >= 0; i--) val = val * 256 + longint'(ref_mem[addr + 32'(i)]);
            if (!uns && val >= (longint'(1) << (8 * n - 1))) val = val - (longint'(1) << (8 * n));
            rdata = 32'(val);
        end
    endtask

    // Byte memory: acks each beat after wait_cycles, checks beat stability, acks stray when idle
    initial begin
        int          cur;
        logic [31:0] a0;
        logic        we0;
        logic [7:0]  wd0;
        cur = 0;
        a0 = '0;
        we0 = 1'b0;
        wd0 = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !bus.mem_req) begin
                cur = 0;
                bus.mem_ack = rst_n && ($urandom_range(0, 1) == 1);
                bus.mem_rdata = 8'($urandom);
            end else begin
                if (cur == 0) begin
                    a0 = bus.mem_addr;
                    we0 = bus.mem_we;
                    wd0 = bus.mem_wdata;
                end else begin
                    check("beat_stable", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                          64'({we0, a0, wd0}));
                end
                if (cur < wait_cycles) begin
                    bus.mem_ack = 1'b0;
                    bus.mem_rdata = 8'($urandom);
                    cur++;
                end else begin
                    bus.mem_ack = 1'b1;
                    beat_addr_q.push_back(a0);
                    beat_we_q.push_back(we0);
                    beat_wd_q.push_back(wd0);
                    if (we0) dut_mem[a0] = wd0;
                    else     bus.mem_rdata = dut_mem[a0];
                    cur = 0;
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n;
        int guard;
        wait_cycles = waits;
        beat_addr_q.delete();
        beat_we_q.delete();
        beat_wd_q.delete();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_size = size;
        bus.req_unsigned = uns;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 64'(bus.req_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we = 1'($urandom);
        bus.req_size = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr = $urandom;
        bus.req_wdata = $urandom;
        lat = 1;
        while (!bus.resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("resp_seen", 64'(bus.resp_valid), 64'(1));
        rdata = bus.resp_rdata;
        err = bus.resp_err;
        @(negedge clk);
        check("resp_one_cycle", 64'({bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.req_ready}),
              64'({1'b0, 1'b0, 32'h0, 1'b1}));
        n = (size == 2'b11) ? 0 : (1 << size);
        check("beat_count", 64'(beat_addr_q.size()), 64'(n));
        for (int i = 0; i < n && i < beat_addr_q.size(); i++) begin
            check("beat_addr", 64'({beat_we_q[i], beat_addr_q[i]}), 64'({we, addr + 32'(i)}));
            if (we) check("beat_wdata", 64'(beat_wd_q[i]), 64'(8'(wdata >> (8 * i))));
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_rd;
        logic        er;
        logic        exp_er;
        int          lat;
        int          guard;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;

        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;

        poke(32'h0001_0005, 8'h80);
        poke(32'h0001_0003, 8'h34);
        poke(32'h0001_0004, 8'h92);
        poke(32'hFFFF_FFFE, 8'h11);
        poke(32'hFFFF_FFFF, 8'h22);
        poke(32'h0000_0000, 8'h33);
        poke(32'h0000_0001, 8'h44);

        //            we    size   uns   addr          wdata         w  rdata         err  lat
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0001_0005, 32'h0,        0, 32'hFFFF_FF80, 1'b0, 2});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0001_0005, 32'h0,        0, 32'h0000_0080, 1'b0, 2});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0001_0003, 32'h0,        2, 32'hFFFF_9234, 1'b0, 7});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0001_0003, 32'h0,        2, 32'h0000_9234, 1'b0, 7});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0,        1, 32'h4433_2211, 1'b0, 9});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h0001_0000, 32'h0,        0, 32'h0,         1'b1, 1});
        vecs.push_back('{1'b1, 2'b11, 1'b0, 32'h0001_0000, 32'hFFFF_FFFF, 0, 32'h0,        1'b1, 1});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF, 0, 32'h0,        1'b0, 5});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0,        0, 32'hDEAD_BEEF, 1'b0, 5});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0002_0001, 32'h1234_5678, 0, 32'h0,        1'b0, 3});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0002_0002, 32'h0,        0, 32'h0000_0056, 1'b0, 2});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0002_0001, 32'h0,        1, 32'h0000_5678, 1'b0, 5});

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_req, bus.mem_we}),
              64'(0));
        check("reset_data", 64'({bus.resp_rdata, bus.mem_addr}), 64'(0));
        check("reset_wdata", 64'(bus.mem_wdata), 64'(0));
        rst_n = 1'b1;
        #1 check("ready_after_reset", 64'(bus.req_ready), 64'(1));

        foreach (vecs[i]) begin
            ref_exec(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, exp_rd, exp_er);
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                   rd, er, lat);
            check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
        end

        // Reset in the middle of beat 2 of a word store
        wait_cycles = 2;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0003_0000;
        bus.req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        guard = 0;
        while (!(bus.mem_req && bus.mem_addr == 32'h0003_0002) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reached_beat2", 64'({bus.mem_req, bus.mem_addr}), 64'({1'b1, 32'h0003_0002}));
        #1 rst_n = 1'b0;
        #1 check("abort_mem_req_async", 64'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_resp", 64'({bus.resp_valid, bus.req_ready}), 64'(0));
        end
        rst_n = 1'b1;
        #1 check("abort_ready_after_release", 64'(bus.req_ready), 64'(1));
        @(negedge clk);
        check("abort_no_late_resp", 64'(bus.resp_valid), 64'(0));
        ref_mem[32'h0003_0000] = 8'h0D;
        ref_mem[32'h0003_0001] = 8'hF0;
        do_req(1'b0, 2'b00, 1'b1, 32'h0003_0001, 32'h0, 0, rd, er, lat);
        check("abort_partial_byte1", 64'({er, rd}), 64'({1'b0, 32'h0000_00F0}));
        do_req(1'b0, 2'b00, 1'b0, 32'h0003_0002, 32'h0, 1, rd, er, lat);
        check("abort_unwritten_byte2", 64'({er, rd}), 64'({1'b0, 32'h0}));
        check("abort_followup_latency", 64'(lat), 64'(3));

        for (int t = 0; t < 150; t++) begin
            we = 1'($urandom);
            size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            uns = 1'($urandom);
            addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 7))
                                               : 32'h0004_0000 + 32'($urandom_range(0, 15));
            wdata = $urandom;
            waits = $urandom_range(0, 2);
            ref_exec(we, size, uns, addr, wdata, exp_rd, exp_er);
            do_req(we, size, uns, addr, wdata, waits, rd, er, lat);
            check("rand_rdata", 64'(rd), 64'(exp_rd));
            check("rand_err", 64'(er), 64'(exp_er));
            check("rand_latency", 64'(lat),
                  64'((size == 2'b11) ? 1 : (1 << size) * (waits + 1) + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lsu_byte_initiator.md
Name: lsu_byte_initiator

Overview:
- Load/store initiator between the pipeline MEM stage and a byte-wide data memory port.
- Accepts one word, half-word or byte load/store per request and splits it into little-endian byte transactions on a req/ack memory handshake.
- Reassembles load data and sign- or zero-extends it. Returns one response per request.
- Handles misaligned addresses naturally, because every memory beat is a single byte.

Parameters:
- DATA_WIDTH, 32, CPU-side data width; fixed at 32 for this block.
- ADDR_WIDTH, 32, byte address width on both sides.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  CPU request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1=store, 0=load
- req_size  input  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data; low bytes used for sub-word sizes
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_err  output  1  qualifies resp_valid; 1 for an illegal size
- mem_req  output  1  byte transaction request
- mem_we  output  1  byte write enable
- mem_addr  output  ADDR_WIDTH  byte address of the current beat
- mem_wdata  output  8  store byte
- mem_ack  input  1  memory completes the current beat
- mem_rdata  input  8  load byte; valid when mem_ack=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - req_ready=0 during reset, 1 after release.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All internal registers cleared.
- FSM states IDLE, ACCESS, RESP.
  - IDLE: req_ready=1. Handshake is req_valid&req_ready on a rising edge.
    - On handshake, latch we, size, unsigned, addr and wdata.
    - Set beat count N = 1/2/4 for size 00/01/10.
    - Clear beat index k and the assembly register. Go to ACCESS.
    - On handshake with size=11: go to RESP with err=1 and no memory beats.
  - ACCESS: mem_req=1, mem_we=latched we.
    - mem_addr = addr + k, modulo 2^ADDR_WIDTH (0xFFFFFFFF+1 wraps to 0x00000000).
    - mem_wdata = wdata[8k+7:8k].
    - mem_req and all mem_* outputs are held stable until mem_ack=1.
    - On mem_ack for a load, capture mem_rdata into byte lane k.
    - On mem_ack, k increments. If k was N-1, go to RESP; otherwise stay in ACCESS.
    - mem_ack while mem_req=0 is ignored.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0.
- Load extension:
  - Byte: bit 7 replicated into [31:8] when signed; zeros when unsigned.
  - Half: bit 15 replicated into [31:16] when signed; zeros when unsigned.
  - Word: unchanged.
- Store: resp_rdata=0.
- resp_rdata and resp_err are valid only while resp_valid=1; they are driven to 0 otherwise.
- Latency: request accepted at edge E. First mem_req is high in the cycle after E.
  - Each beat takes 1 + (wait cycles before mem_ack).
  - resp_valid is high in the cycle after the last ack.
  - Zero-wait word: 4 beat cycles + 1 response cycle; next accept possible on the following edge.
- Back-to-back: req_ready is 0 from acceptance through the RESP cycle, so there is no overlap. req_valid held high is accepted on the first IDLE edge.
- Reset mid-operation: mem_req drops immediately (async). The in-flight access is abandoned and no response is issued. Partial stores already acknowledged remain in memory.
- No data buffering beyond the latched request. Only one outstanding request at a time.

Test Plan:
- Zero-wait word store: addr=0x00010000, wdata=0xDEADBEEF. Expect beats 0x10000..0x10003 with bytes EF,BE,AD,DE, then resp_valid with err=0 and rdata=0.
- Signed byte load: memory[0x10005]=0x80, size=00, unsigned=0. Expect rdata=0xFFFFFF80; same with unsigned=1 → 0x00000080.
- Misaligned signed half load with wait states:
  - addr=0x10003, memory 0x10003=0x34, 0x10004=0x92.
  - mem_ack delayed 2 cycles per beat; mem_addr and mem_req must stay stable during the wait.
  - Expect rdata=0xFFFF9234, with resp_valid 7 cycles after accept.
- Address wrap: word load at addr=0xFFFFFFFE. Expect mem_addr sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- Illegal size=11: expect no mem_req, and resp_valid with err=1 and rdata=0 exactly one cycle after accept.
- Reset during beat 2 of a word store: expect mem_req=0 asynchronously, no resp_valid, and req_ready=1 after release. A following byte load completes normally.
